// File: rtl/kernel_loader9_if.sv
// Weight-loader bus: start/base request, SRAM read port, rotator write port and kernel status.
interface kernel_loader9_if #(
   parameter int unsigned BUS_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH = 12
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] sram_read_address;
   logic [BUS_WIDTH-1:0]  sram_read_data;
   logic                  wen;
   logic [BUS_WIDTH-1:0]  write_bus;
   logic                  kernel_valid;
   logic [3:0]            tap_index;
   logic [BUS_WIDTH+3:0]  kernel_sum;

   modport master (
      input  start, base_addr, sram_read_data,
      output busy, sram_read_address, wen, write_bus, kernel_valid, tap_index, kernel_sum
   );

   modport slave (
      output start, base_addr, sram_read_data,
      input  busy, sram_read_address, wen, write_bus, kernel_valid, tap_index, kernel_sum
   );
endinterface

// File: rtl/kernel_loader9.sv
// Fetches nine SRAM weights into the rotating kernel register and tracks rotation phase.
// Optional running weight sum enabled by defining KERNEL_LOADER9_SUM_EN.
module kernel_loader9 #(
   parameter int unsigned BUS_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input logic             clock,
   input logic             reset,
   kernel_loader9_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

   state_t                state, state_next;
   logic [3:0]            fetch_count;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  read_valid;
   logic [3:0]            tap;
   logic                  load_start;

   assign load_start = bus.start && (state == IDLE || state == VALID);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = FETCH;
         FETCH:   if (fetch_count == 4'd8) state_next = DRAIN;
         DRAIN:   state_next = VALID;
         VALID:   if (bus.start) state_next = FETCH;
         default: state_next = IDLE;
      endcase
   end

   // Read-valid lags each address by one cycle to match the SRAM read latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr        <= '0;
         fetch_count <= '0;
         read_valid  <= 1'b0;
         tap         <= '0;
      end else begin
         read_valid <= (state == FETCH);
         if (load_start) begin
            addr        <= bus.base_addr;
            fetch_count <= '0;
         end else if (state == FETCH && fetch_count != 4'd8) begin
            addr        <= addr + 1'b1;
            fetch_count <= fetch_count + 4'd1;
         end
         if (state == VALID) tap <= (tap == 4'd8) ? 4'd0 : tap + 4'd1;
         else                tap <= '0;
      end
   end

   always_comb begin
      bus.busy              = (state == FETCH) || (state == DRAIN);
      bus.kernel_valid      = (state == VALID);
      bus.tap_index         = (state == VALID) ? tap : 4'd0;
      bus.sram_read_address = addr;
      bus.wen               = read_valid;
      bus.write_bus         = read_valid ? bus.sram_read_data : '0;
   end

`ifdef KERNEL_LOADER9_SUM_EN
   logic [BUS_WIDTH+3:0] acc;
   logic [BUS_WIDTH+3:0] sum_q;

   // The final word is folded in directly so the sum is ready when VALID begins.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc   <= '0;
         sum_q <= '0;
      end else if (load_start) begin
         acc   <= '0;
         sum_q <= '0;
      end else if (read_valid) begin
         acc <= acc + (BUS_WIDTH+4)'(bus.sram_read_data);
         if (state == DRAIN) sum_q <= acc + (BUS_WIDTH+4)'(bus.sram_read_data);
      end
   end

   assign bus.kernel_sum = sum_q;
`else
   assign bus.kernel_sum = '0;
`endif

endmodule

// File: tb/tb_kernel_loader9.sv
// Scoreboard bench for kernel_loader9: SRAM model, rotator model, write-data queue and phase checks.
module tb_kernel_loader9;
   localparam int BW = 16;
   localparam int AW = 12;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   kernel_loader9_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

   kernel_loader9 #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   logic [BW-1:0] mem [0:4095];
   logic [BW-1:0] rdata;
   always @(posedge clock) rdata <= mem[bus.sram_read_address];
   assign bus.sram_read_data = rdata;

   // Rotator model: shifts in on wen, otherwise rotates; output is rot[0].
   logic [BW-1:0] rot [0:8];
   always @(posedge clock) begin
      for (int i = 0; i < 8; i++) rot[i] <= rot[i+1];
      rot[8] <= bus.wen ? bus.write_bus : rot[0];
   end

   logic [BW-1:0] exp_w [$];
   logic [BW-1:0] exp_kernel [9];
   logic [BW-1:0] wts [9];
   logic [BW-1:0] mon_e;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            tb_tap   = 0;
   logic          prev_kv  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected write word on every wen, checks phase while valid.
   always @(negedge clock) begin
      if (bus.wen) begin
         if (exp_w.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wen_unexpected: got wen=1 data 0x%0h expected no write (t=%0t)", bus.write_bus, $time);
         end else begin
            mon_e = exp_w.pop_front();
            check("write_bus", 32'(bus.write_bus), 32'(mon_e));
         end
      end
      if (bus.kernel_valid) begin
         if (!prev_kv) tb_tap = 0;
         check("tap_index", 32'(bus.tap_index), tb_tap);
         check("rotator_out", 32'(rot[0]), 32'(exp_kernel[tb_tap]));
         tb_tap = (tb_tap == 8) ? 0 : tb_tap + 1;
      end else begin
         check("tap_idle", 32'(bus.tap_index), 0);
      end
      prev_kv = bus.kernel_valid;
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic load(input logic [AW-1:0] b, input int spur_at, input int rst_at);
      logic [BW+3:0] esum;
      logic [AW-1:0] ea;
      esum = '0;
      for (int i = 0; i < 9; i++) begin
         mem[b + AW'(i)] = wts[i];
         exp_w.push_back(wts[i]);
         esum += (BW+4)'(wts[i]);
      end
`ifndef KERNEL_LOADER9_SUM_EN
      esum = '0;
`endif
      bus.base_addr = b;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) exp_kernel[i] = wts[i];
      for (int k = 1; k <= 10; k++) begin
         ea = b + AW'(k - 1);
         check("busy_load", 32'(bus.busy), 1);
         check("kv_load", 32'(bus.kernel_valid), 0);
         check("wen_timing", 32'(bus.wen), 32'(k >= 2));
         check("sum_cleared", 32'(bus.kernel_sum), 0);
         if (k <= 9) check("read_address", 32'(bus.sram_read_address), 32'(ea));
         if (k == spur_at) bus.start = 1'b1;
         if (k == rst_at) reset = 1'b1;
         step();
         bus.start = 1'b0;
         if (k == rst_at) begin
            reset = 1'b0;
            exp_w.delete();
            for (int j = 0; j < 3; j++) begin
               check("abort_busy", 32'(bus.busy), 0);
               check("abort_wen", 32'(bus.wen), 0);
               check("abort_write_bus", 32'(bus.write_bus), 0);
               check("abort_addr", 32'(bus.sram_read_address), 0);
               check("abort_kv", 32'(bus.kernel_valid), 0);
               step();
            end
            return;
         end
      end
      check("kv_ready", 32'(bus.kernel_valid), 1);
      check("busy_done", 32'(bus.busy), 0);
      check("tap_first", 32'(bus.tap_index), 0);
      check("wen_done", 32'(bus.wen), 0);
      check("kernel_sum", 32'(bus.kernel_sum), 32'(esum));
      check("wen_count", exp_w.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start     = 1'b0;
      bus.base_addr = '0;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      for (int i = 0; i < 9; i++) exp_kernel[i] = '0;
      repeat (3) step();
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_wen", 32'(bus.wen), 0);
      check("rst_write_bus", 32'(bus.write_bus), 0);
      check("rst_addr", 32'(bus.sram_read_address), 0);
      check("rst_kv", 32'(bus.kernel_valid), 0);
      check("rst_tap", 32'(bus.tap_index), 0);
      check("rst_sum", 32'(bus.kernel_sum), 0);
      // Reset and start together: reset wins.
      bus.start = 1'b1;
      bus.base_addr = 12'h040;
      step();
      bus.start = 1'b0;
      reset = 1'b0;
      check("rst_start_busy", 32'(bus.busy), 0);
      step();

      // Weights 1..9 from 0x010, then hold VALID for 20 cycles.
      for (int i = 0; i < 9; i++) wts[i] = BW'(i + 1);
      load(12'h010, 0, 0);
      repeat (20) step();
      check("tap_after_20", 32'(bus.tap_index), 2);
      check("kv_hold", 32'(bus.kernel_valid), 1);

      // Reload from VALID with address wrap past 0xFFF.
      for (int i = 0; i < 9; i++) wts[i] = BW'(16'hA000 + i);
      load(12'hFFE, 0, 0);
      repeat (10) step();

      // Spurious start during FETCH is ignored.
      for (int i = 0; i < 9; i++) wts[i] = BW'(16'h1230 + 3 * i);
      load(12'h100, 4, 0);
      repeat (12) step();

      // Reset mid-load aborts.
      for (int i = 0; i < 9; i++) wts[i] = BW'(16'h0B00 + i);
      load(12'h200, 0, 5);
      repeat (3) step();
      check("abort_kv_late", 32'(bus.kernel_valid), 0);
      check("abort_busy_late", 32'(bus.busy), 0);

      // All-ones weights: maximum sum.
      for (int i = 0; i < 9; i++) wts[i] = 16'hFFFF;
      load(12'h300, 0, 0);
      repeat (3) step();
`ifdef KERNEL_LOADER9_SUM_EN
      check("sum_ffff", 32'(bus.kernel_sum), 32'h8FFF7);
`else
      check("sum_ffff", 32'(bus.kernel_sum), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/kernel_loader9.md
# kernel_loader9

Weight-fetch controller that drives the 9-entry rotating kernel shift register. On a start pulse it reads nine consecutive words from weight SRAM (1-cycle read latency), streams them into the rotator via `wen`/`write_bus`, then tracks rotation phase so the MAC datapath knows which of the nine weights sits on the rotator's output each cycle. It is the writer and sequencer at the input end of the rotator and sits between weight SRAM and the convolution MAC.

## Interface
- `BUS_WIDTH`, 16, weight word width; matches the rotator's bus.
- `ADDR_WIDTH`, 12, SRAM word-address width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to load a kernel from `base_addr`.
- `base_addr`  in  ADDR_WIDTH  address of weight 0; sampled with `start`.
- `busy`  out  1  high while a load is in progress.
- `sram_read_address`  out  ADDR_WIDTH  registered SRAM read address.
- `sram_read_data`  in  BUS_WIDTH  SRAM data, valid one cycle after its address.
- `wen`  out  1  rotator write enable.
- `write_bus`  out  BUS_WIDTH  rotator write data.
- `kernel_valid`  out  1  rotator holds a complete kernel.
- `tap_index`  out  4  index (0..8) of the weight on the rotator output this cycle.
- `kernel_sum`  out  BUS_WIDTH+4  unsigned sum of the nine loaded weights.

## Operation
- States: IDLE, FETCH, DRAIN, VALID.
- IDLE: `start`=1 captures `base_addr`, clears the fetch counter, moves to FETCH, and drops `kernel_valid`.
- FETCH: 9 cycles. `sram_read_address` = base+k for k=0..8, with modulo 2^ADDR_WIDTH wrap (base 0xFFF, width 12 → 0xFFF, 0x000, …, 0x007). After k=8 → DRAIN.
- A 1-bit registered read-valid pipe delays each issue by one cycle. While it is set, `wen`=1 and `write_bus`=`sram_read_data`, combinationally passed through. When it is clear, `wen`=0 and `write_bus`=0.
- DRAIN: 1 cycle. The last word (k=8) is written, then → VALID.
- VALID: `kernel_valid`=1. `tap_index` starts at 0 and increments each cycle, wrapping 8→0; it tracks rotator output W0, W1, …, W8, W0, …
- `start` in VALID begins a reload, same as from IDLE. `kernel_valid` deasserts the next cycle.
- `start` in FETCH or DRAIN is ignored; no queuing.
- `busy` is high in FETCH and DRAIN only.
- Outside VALID, `tap_index` is held at 0.

## Timing
- Let `start` be sampled at the edge ending cycle T.
- Addresses are presented in cycles T+1..T+9. `wen` is high in cycles T+2..T+10, carrying W0..W8.
- `busy` is high in cycles T+1..T+10.
- From cycle T+11, `kernel_valid`=1 and `tap_index`=0; the rotator output is W0.
- Start-to-first-usable-weight latency is 11 cycles.
- Reset values: `busy`=0, `wen`=0, `write_bus`=0, `sram_read_address`=0, `kernel_valid`=0, `tap_index`=0, `kernel_sum`=0. State → IDLE.
- Reset mid-load aborts immediately. The next cycle drives all outputs at reset values, and the read-valid pipe is cleared, so no stray `wen`. Rotator contents are don't-care until a new load completes.
- `reset` and `start` in the same cycle: reset wins and `start` is lost.

## Configuration
- `KERNEL_LOADER9_SUM_EN` defined:
  - Each word is added into a BUS_WIDTH+4 accumulator as it is written. The accumulator clears when a load starts.
  - `kernel_sum` is updated after W8 is written and holds from T+11 until the next load starts, when it clears to 0.
  - The sum is unsigned and cannot overflow (9 × (2^BUS_WIDTH−1) < 2^(BUS_WIDTH+4)).
- Undefined: the accumulator logic is absent and `kernel_sum` is tied to 0. The port is retained.

## Test plan
- Reset, then `start` with base=0x010 and SRAM[0x010+i]=i+1 → addresses 0x010..0x018 in T+1..T+9; `wen` in T+2..T+10 with data 1..9; `busy` in T+1..T+10; `kernel_valid` and `tap_index`=0 at T+11, with rotator output 1.
- Hold VALID for 20 cycles → `tap_index` sequence 0..8, 0..8, 0, 1 and rotator output (value−1) equal to `tap_index` every cycle.
- base=0xFFE → addresses 0xFFE, 0xFFF, 0x000..0x006; loaded kernel correct.
- `start` pulsed at T+4 during FETCH → ignored; exactly 9 `wen` cycles. `start` pulsed in VALID with new data → `kernel_valid` low in T'+1..T'+10, new kernel valid at T'+11.
- `reset` asserted at T+5 → from T+6, `wen`=0 and `busy`=0 with no further addresses; `kernel_valid` stays 0 until a fresh load.
- With `KERNEL_LOADER9_SUM_EN` and all weights 0xFFFF → `kernel_sum`=0x8FFF7 from T+11. Without the macro → `kernel_sum`=0 throughout.
